// File: rtl/commit_pkg.sv
// Shared types for the commit checker: entry layout, mismatch codes,
// checker state and the store-data normalisation helper.
package commit_pkg;

   typedef enum logic {
      KIND_REG   = 1'b0,
      KIND_STORE = 1'b1
   } commit_kind_e;

   // Values are the externally visible mismatch_code encoding.
   typedef enum logic [2:0] {
      MM_NONE      = 3'd0,
      MM_PC        = 3'd1,
      MM_INST      = 3'd2,
      MM_KIND      = 3'd3,
      MM_RD        = 3'd4,
      MM_DATA      = 3'd5,
      MM_ADDR      = 3'd6,
      MM_UNDERFLOW = 3'd7
   } mismatch_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_FAIL = 1'b1
   } chk_state_e;

   typedef struct packed {
      commit_kind_e kind;
      logic [31:0]  pc;
      logic [31:0]  inst;
      logic [5:0]   rd;
      logic [31:0]  addr;
      logic [31:0]  data;
   } commit_entry_t;

   // inst[6:2] of conditional branches; these never write a register.
   localparam logic [4:0] OPC_BRANCH = 5'b11000;

   // Bring lane-positioned store data down to bit 0 and keep only the
   // bytes the store width (funct3) actually writes.
   function automatic logic [31:0] norm_store_data(input logic [31:0] lane_data,
                                                   input logic [1:0]  byte_off,
                                                   input logic [2:0]  funct3);
      logic [31:0] s;
      s = lane_data >> {byte_off, 3'b000};
      case (funct3)
         3'b000:  return {24'h0, s[7:0]};
         3'b001:  return {16'h0, s[15:0]};
         default: return s;
      endcase
   endfunction

endpackage

// File: rtl/commit_checker_if.sv
// Golden-trace entry port and DUT commit stream seen by the checker.
// Handshake: an expected entry transfers on a clock edge where
// exp_valid && exp_ready; the source holds the entry stable while
// exp_valid is high and ready is low. Commit signals are a plain strobe
// (commit_valid) with no back-pressure.
interface commit_checker_if;
   import commit_pkg::*;

   logic         exp_valid;
   logic         exp_ready;
   logic         exp_kind;
   logic [31:0]  exp_pc;
   logic [31:0]  exp_inst;
   logic [5:0]   exp_rd;
   logic [31:0]  exp_addr;
   logic [31:0]  exp_data;

   logic         commit_valid;
   logic [31:0]  commit_pc;
   logic [31:0]  commit_inst;
   logic [5:0]   commit_Ard;
   logic [31:0]  commit_data;
   logic         st_commit;
   logic [31:0]  st_addr;
   logic [31:0]  st_data;

   modport master (
      output exp_valid, exp_kind, exp_pc, exp_inst, exp_rd, exp_addr, exp_data,
      output commit_valid, commit_pc, commit_inst, commit_Ard, commit_data,
      output st_commit, st_addr, st_data,
      input  exp_ready
   );

   modport slave (
      input  exp_valid, exp_kind, exp_pc, exp_inst, exp_rd, exp_addr, exp_data,
      input  commit_valid, commit_pc, commit_inst, commit_Ard, commit_data,
      input  st_commit, st_addr, st_data,
      output exp_ready
   );

endinterface

// File: rtl/commit_exp_fifo.sv
// Expected-entry FIFO. Head is read combinationally from storage, so an
// entry written this cycle is only visible at the head next cycle.
module commit_exp_fifo
   import commit_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  commit_entry_t            din,
   input  logic                     pop,
   output commit_entry_t            head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   commit_entry_t  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/commit_checker.sv
// Compares each loggable DUT commit against the head of the golden-trace
// FIFO, latches the first divergence (field + pc) and then stops checking.
module commit_checker
   import commit_pkg::*;
#(
   parameter int          DEPTH  = 16,
   parameter logic [31:0] PC_MIN = 32'h0000_2000
) (
   input  logic                    clk,
   input  logic                    rst,
   commit_checker_if.slave         bus,
   output logic                    mismatch,
   output logic [2:0]              mismatch_code,
   output logic [31:0]             mismatch_pc,
   output logic [31:0]             match_count,
   output logic [$clog2(DEPTH):0]  pending,
   output chk_state_e              state
);

   chk_state_e     state_d;
   commit_entry_t  head;
   commit_entry_t  push_entry;
   logic           fifo_full;
   logic           fifo_empty;
   logic           push;
   logic           pop;
   logic           is_store;
   logic           is_reg;
   logic           check_en;
   logic           fail_now;
   commit_kind_e   dut_kind;
   logic [31:0]    dut_data;
   mismatch_e      cmp_code;

   // Ready is a function of registered state only, never of the commit inputs.
   assign bus.exp_ready = (state == ST_RUN) && !fifo_full;
   assign push          = bus.exp_valid && bus.exp_ready;

   assign push_entry = '{kind: commit_kind_e'(bus.exp_kind), pc: bus.exp_pc,
                         inst: bus.exp_inst, rd: bus.exp_rd,
                         addr: bus.exp_addr, data: bus.exp_data};

   commit_exp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .head  (head),
      .count (pending),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Classify the commit and bring store data into the golden-trace format.
   always_comb begin
      is_store = bus.st_commit;
      is_reg   = !bus.st_commit && (bus.commit_Ard != 6'd0) &&
                 (bus.commit_inst[6:2] != OPC_BRANCH);
      dut_kind = is_store ? KIND_STORE : KIND_REG;
      dut_data = is_store ? norm_store_data(bus.st_data, bus.st_addr[1:0],
                                            bus.commit_inst[14:12])
                          : bus.commit_data;
      check_en = (state == ST_RUN) && bus.commit_valid &&
                 (bus.commit_pc >= PC_MIN) && (is_store || is_reg);
   end

   // Field compare against the FIFO head; earlier tests take priority.
   always_comb begin
      cmp_code = MM_NONE;
      if (fifo_empty)                                            cmp_code = MM_UNDERFLOW;
      else if (bus.commit_pc != head.pc)                         cmp_code = MM_PC;
      else if (bus.commit_inst != head.inst)                     cmp_code = MM_INST;
      else if (dut_kind != head.kind)                            cmp_code = MM_KIND;
      else if (is_reg && (bus.commit_Ard != head.rd))            cmp_code = MM_RD;
      else if (is_store && (bus.st_addr != head.addr))           cmp_code = MM_ADDR;
      else if (dut_data != head.data)                            cmp_code = MM_DATA;
   end

   assign pop      = check_en && (cmp_code == MM_NONE);
   assign fail_now = check_en && (cmp_code != MM_NONE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_RUN;
      else      state <= state_d;
   end

   // Next state: FAIL is entered on the first mismatch and only reset leaves it.
   always_comb begin
      state_d = state;
      case (state)
         ST_RUN:  if (fail_now) state_d = ST_FAIL;
         default: state_d = ST_FAIL;
      endcase
   end

   // Result registers: first-failure latch and matched-commit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mismatch      <= 1'b0;
         mismatch_code <= 3'd0;
         mismatch_pc   <= 32'h0;
         match_count   <= 32'h0;
      end else begin
         if (fail_now) begin
            mismatch      <= 1'b1;
            mismatch_code <= cmp_code;
            mismatch_pc   <= bus.commit_pc;
         end
         if (pop) match_count <= match_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker with an expected-result scoreboard.
module tb_commit_checker;
   import commit_pkg::*;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic        mm;
      logic [2:0]  code;
      logic [31:0] mpc;
      logic [31:0] cnt;
      logic [4:0]  pend;
   } res_t;

   logic        clk;
   logic        rst;
   logic        dut_mismatch;
   logic [2:0]  dut_code;
   logic [31:0] dut_mpc;
   logic [31:0] dut_cnt;
   logic [4:0]  dut_pend;
   chk_state_e  dut_state;

   int n_checks;
   int n_errors;

   res_t exp_q[$];

   // Bench-side expectation of the checker's observable state.
   bit          m_fail;
   logic [2:0]  m_code;
   logic [31:0] m_mpc;
   logic [31:0] m_cnt;
   int          m_pend;

   commit_entry_t fe [16];
   commit_entry_t ea, eb, esh, esw, ec, ex;

   commit_checker_if bus ();

   commit_checker #(.DEPTH(DEPTH), .PC_MIN(32'h0000_2000)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .mismatch      (dut_mismatch),
      .mismatch_code (dut_code),
      .mismatch_pc   (dut_mpc),
      .match_count   (dut_cnt),
      .pending       (dut_pend),
      .state         (dut_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input string field,
                      input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
      end
   endtask

   function automatic commit_entry_t mk(input commit_kind_e k, input logic [31:0] pc,
                                        input logic [31:0] inst, input logic [5:0] rd,
                                        input logic [31:0] addr, input logic [31:0] data);
      commit_entry_t e;
      e.kind = k; e.pc = pc; e.inst = inst; e.rd = rd; e.addr = addr; e.data = data;
      return e;
   endfunction

   // Driver tasks
   task automatic idle();
      bus.exp_valid    = 1'b0;
      bus.commit_valid = 1'b0;
      bus.st_commit    = 1'b0;
   endtask

   task automatic put_exp(input commit_entry_t e);
      bus.exp_valid = 1'b1;
      bus.exp_kind  = e.kind;
      bus.exp_pc    = e.pc;
      bus.exp_inst  = e.inst;
      bus.exp_rd    = e.rd;
      bus.exp_addr  = e.addr;
      bus.exp_data  = e.data;
   endtask

   task automatic put_reg(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [5:0] rd, input logic [31:0] data);
      bus.commit_valid = 1'b1;
      bus.st_commit    = 1'b0;
      bus.commit_pc    = pc;
      bus.commit_inst  = inst;
      bus.commit_Ard   = rd;
      bus.commit_data  = data;
      bus.st_addr      = 32'h0;
      bus.st_data      = 32'h0;
   endtask

   task automatic put_st(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] addr, input logic [31:0] data);
      bus.commit_valid = 1'b1;
      bus.st_commit    = 1'b1;
      bus.commit_pc    = pc;
      bus.commit_inst  = inst;
      bus.commit_Ard   = 6'd0;
      bus.commit_data  = 32'h0;
      bus.st_addr      = addr;
      bus.st_data      = data;
   endtask

   // One clock with whatever is driven. outcome: -1 no checked commit,
   // 0 expected match, 1..7 expected mismatch code.
   task automatic step(input string tag, input int outcome);
      res_t r;
      bit   push_ok;
      chk(tag, "exp_ready", {31'b0, bus.exp_ready}, {31'b0, (!m_fail && m_pend < DEPTH)});
      push_ok = bus.exp_valid && !m_fail && (m_pend < DEPTH);
      if (outcome == 0) begin
         m_pend--;
         m_cnt++;
      end else if (outcome > 0) begin
         m_fail = 1'b1;
         m_code = 3'(outcome);
         m_mpc  = bus.commit_pc;
      end
      if (push_ok) m_pend++;
      r.mm = m_fail; r.code = m_code; r.mpc = m_mpc; r.cnt = m_cnt; r.pend = 5'(m_pend);
      exp_q.push_back(r);
      @(posedge clk);
      #1;
      idle();
      r = exp_q.pop_front();
      chk(tag, "mismatch", {31'b0, dut_mismatch}, {31'b0, r.mm});
      chk(tag, "code", {29'b0, dut_code}, {29'b0, r.code});
      chk(tag, "mismatch_pc", dut_mpc, r.mpc);
      chk(tag, "match_count", dut_cnt, r.cnt);
      chk(tag, "pending", {27'b0, dut_pend}, {27'b0, r.pend});
   endtask

   task automatic model_clear();
      m_fail = 1'b0; m_code = 3'd0; m_mpc = 32'h0; m_cnt = 32'h0; m_pend = 0;
      exp_q.delete();
   endtask

   task automatic chk_reset(input string tag);
      chk(tag, "mismatch", {31'b0, dut_mismatch}, 32'd0);
      chk(tag, "code", {29'b0, dut_code}, 32'd0);
      chk(tag, "mismatch_pc", dut_mpc, 32'd0);
      chk(tag, "match_count", dut_cnt, 32'd0);
      chk(tag, "pending", {27'b0, dut_pend}, 32'd0);
      chk(tag, "exp_ready", {31'b0, bus.exp_ready}, 32'd1);
      chk(tag, "state", {31'b0, dut_state}, {31'b0, ST_RUN});
   endtask

   task automatic reset_dut();
      idle();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence
   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      idle();
      put_reg(32'h0, 32'h0, 6'd0, 32'h0);
      idle();
      model_clear();

      ea  = mk(KIND_REG,   32'h2000, 32'h0050_0093, 6'd1, 32'h0,    32'h5);
      eb  = mk(KIND_STORE, 32'h2004, 32'h0020_8123, 6'd0, 32'h1002, 32'hAB);
      esh = mk(KIND_STORE, 32'h2008, 32'h0020_9223, 6'd0, 32'h1006, 32'hBEEF);
      esw = mk(KIND_STORE, 32'h200C, 32'h0020_A423, 6'd0, 32'h1008, 32'hDEAD_BEEF);
      ec  = mk(KIND_REG,   32'h2014, 32'h0010_8113, 6'd2, 32'h0,    32'h11);
      ex  = mk(KIND_REG,   32'h3040, 32'h00A0_0093, 6'd1, 32'h0,    32'd10);
      for (int i = 0; i < 16; i++)
         fe[i] = mk(KIND_REG, 32'h3000 + 32'(i * 4), 32'h0000_0093 | (32'(i) << 20),
                    6'd1, 32'h0, 32'(i));

      reset_dut();
      chk_reset("reset");

      // Basic REG and store matches
      put_exp(ea);                                         step("push_a", -1);
      put_reg(ea.pc, ea.inst, ea.rd, ea.data);             step("cmt_a", 0);
      put_exp(eb);                                         step("push_sb", -1);
      put_st(eb.pc, eb.inst, 32'h1002, 32'h00AB_0000);     step("cmt_sb", 0);
      put_exp(esh);                                        step("push_sh", -1);
      put_st(esh.pc, esh.inst, 32'h1006, 32'hBEEF_1234);   step("cmt_sh", 0);
      put_exp(esw);                                        step("push_sw", -1);
      put_st(esw.pc, esw.inst, 32'h1008, 32'hDEAD_BEEF);   step("cmt_sw", 0);

      // Ignored commits leave the head in place
      put_exp(ec);                                         step("push_c", -1);
      put_reg(32'h1000, ec.inst, ec.rd, ec.data);          step("ign_lowpc", -1);
      put_reg(32'h2008, 32'h0000_0063, 6'd0, 32'h0);       step("ign_branch", -1);
      put_reg(32'h2014, 32'h0000_8063, 6'd5, 32'h0);       step("ign_branch_rd", -1);
      put_reg(ec.pc, 32'h0010_8013, 6'd0, 32'h0);          step("ign_x0", -1);
      put_reg(ec.pc, ec.inst, ec.rd, ec.data);             step("cmt_c", 0);

      // Fill, pop-only when full, then simultaneous push/pop, then drain
      for (int i = 0; i < 16; i++) begin
         put_exp(fe[i]);
         step("fill", -1);
      end
      put_exp(ex);
      put_reg(fe[0].pc, fe[0].inst, fe[0].rd, fe[0].data); step("full_pop", 0);
      put_exp(ex);
      put_reg(fe[1].pc, fe[1].inst, fe[1].rd, fe[1].data); step("push_pop", 0);
      for (int i = 2; i < 16; i++) begin
         put_reg(fe[i].pc, fe[i].inst, fe[i].rd, fe[i].data);
         step("drain", 0);
      end
      put_reg(ex.pc, ex.inst, ex.rd, ex.data);             step("drain_x", 0);

      // Underflow with a push in the same cycle, then frozen FAIL
      reset_dut();
      put_exp(mk(KIND_REG, 32'h2010, 32'h0050_0093, 6'd1, 32'h0, 32'h5));
      put_reg(32'h2010, 32'h0050_0093, 6'd1, 32'h5);       step("underflow", 7);
      put_exp(ea);                                         step("fail_nopush", -1);
      put_reg(32'h2010, 32'h0050_0093, 6'd1, 32'h5);       step("fail_frozen", -1);
      chk("fail", "state", {31'b0, dut_state}, {31'b0, ST_FAIL});

      // Store data mismatch
      reset_dut();
      put_exp(eb);                                         step("push_sb2", -1);
      put_st(eb.pc, eb.inst, 32'h1002, 32'h00AC_0000);     step("mm_data", 5);

      // Instruction mismatch outranks data
      reset_dut();
      put_exp(ea);                                         step("push_i", -1);
      put_reg(ea.pc, 32'h0060_0093, 6'd1, 32'h6);          step("mm_inst", 2);

      // Kind mismatch
      reset_dut();
      put_exp(eb);                                         step("push_k", -1);
      put_reg(eb.pc, eb.inst, 6'd1, 32'hAB);               step("mm_kind", 3);

      // Destination mismatch
      reset_dut();
      put_exp(ea);                                         step("push_rd", -1);
      put_reg(ea.pc, ea.inst, 6'd3, ea.data);              step("mm_rd", 4);

      // Address mismatch outranks data
      reset_dut();
      put_exp(mk(KIND_STORE, 32'h2040, 32'h0020_A423, 6'd0, 32'h1000, 32'h55));
      step("push_ad", -1);
      put_st(32'h2040, 32'h0020_A423, 32'h1004, 32'h66);   step("mm_addr", 6);

      // PC mismatch outranks instruction, then async reset mid-FAIL
      reset_dut();
      put_exp(mk(KIND_REG, 32'h2020, 32'h0050_0093, 6'd1, 32'h0, 32'h5));
      step("push_pc", -1);
      put_reg(32'h2024, 32'h0070_0093, 6'd1, 32'h5);       step("mm_pc", 1);
      rst = 1'b0;
      #2;
      chk_reset("async_reset");
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      put_exp(ea);                                         step("re_push", -1);
      put_reg(ea.pc, ea.inst, ea.rd, ea.data);             step("re_cmt", 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/commit_checker.md
Name: commit_checker

Overview:
- In-order consumer of the commit stream. Counterpart of the commit-log writer: instead of emitting trace lines, it is fed expected commits from a golden trace through a valid/ready port.
- Each loggable DUT commit is compared against the head of an expected-entry FIFO.
- The first divergence is latched with its field and PC, and checking halts.
- Sits in sim/ beside the commit tracker, on the same commit and store-commit signals.

Parameters:
- DEPTH, 16, expected-entry FIFO depth (power of two, ≥2)
- PC_MIN, 32'h0000_2000, commits with pc < PC_MIN are ignored

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- exp_valid  in  1  expected entry offered
- exp_ready  out  1  expected entry accepted when exp_valid && exp_ready
- exp_kind  in  1  0=REG write, 1=STORE
- exp_pc  in  32  expected pc
- exp_inst  in  32  expected instruction
- exp_rd  in  6  expected destination (REG only)
- exp_addr  in  32  expected store address (STORE only)
- exp_data  in  32  REG value, or store data already right-aligned and masked
- commit_valid  in  1  DUT commit strobe
- commit_pc  in  32  DUT pc
- commit_inst  in  32  DUT instruction
- commit_Ard  in  6  DUT destination
- commit_data  in  32  DUT writeback value
- st_commit  in  1  commit is a store
- st_addr  in  32  store address
- st_data  in  32  store data, lane-positioned
- mismatch  out  1  sticky failure flag
- mismatch_code  out  3  first failing field
- mismatch_pc  out  32  commit_pc of the failing commit
- match_count  out  32  number of matched commits
- pending  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst low, async): FIFO empty, state RUN, exp_ready=1, mismatch=0, mismatch_code=0, mismatch_pc=0, match_count=0, pending=0.
- Loggable commit: commit_valid && commit_pc >= PC_MIN, classified as follows.
  - STORE if st_commit.
  - Otherwise REG if commit_Ard != 0 && commit_inst[6:2] != 5'b11000.
  - Otherwise ignored: no pop, no count.
- Store data normalisation:
  - s = st_data >> (st_addr[1:0]*8).
  - funct3 = commit_inst[14:12]: 000 masks s to [7:0], 001 masks to [15:0], otherwise full 32 bits.
- Comparison is combinational against the FIFO head. Results are registered and visible the cycle after the commit.
- Mismatch code priority (first failing test wins):
  - 7 UNDERFLOW: FIFO empty.
  - 1 PC.
  - 2 INST.
  - 3 KIND.
  - 4 RD (REG only).
  - 6 ADDR (STORE only).
  - 5 DATA.
  - 0 means none.
- On match: pop the head; match_count += 1 (wraps at 2^32).
- On mismatch:
  - state → FAIL; latch the code and commit_pc; mismatch=1.
  - The head is not popped.
- FSM:
  - RUN → FAIL on the first mismatch.
  - FAIL is absorbing until reset.
  - In FAIL: no pops, no pushes, exp_ready=0, match_count frozen, latched fields frozen.
- exp_ready = (state==RUN) && !full. It does not depend on commit inputs.
- Push and pop in the same cycle are both performed; pending is unchanged.
- No bypass: an entry pushed in cycle N is first comparable in cycle N+1. A commit in cycle N with an empty FIFO is UNDERFLOW even if a push occurs in N.
- Pointers wrap modulo DEPTH. full = (pending==DEPTH).
- Reset asserted mid-operation clears all state immediately. Entries in flight are discarded.

Decomposition:
- commit_pkg holds:
  - commit_kind_e (REG, STORE).
  - mismatch_e (NONE=0, PC=1, INST=2, KIND=3, RD=4, DATA=5, ADDR=6, UNDERFLOW=7).
  - commit_entry_t struct {kind, pc, inst, rd, addr, data}.
  - OPC_BRANCH = 5'b11000.
- Sub-module commit_exp_fifo (DEPTH-parameterised, commit_entry_t payload, push/pop/count/full/empty). The checker holds the classification, normalisation, compare and FSM.

Test Plan:
- Push REG {pc=0x2000, inst=0x00500093, rd=1, data=5}; DUT commits the same → next cycle match_count=1, mismatch=0, pending=0.
- Push STORE {pc=0x2004, inst=0x00208123 (SB), addr=0x1002, data=0xAB}; DUT st_commit, st_addr=0x1002, st_data=0x00AB0000 → match. Repeat with st_data=0x00AC0000 → mismatch=1, code=5, mismatch_pc=0x2004.
- DUT commits pc=0x1000, and separately a branch (inst[6:2]=11000) at pc=0x2008 with rd=0 → ignored; pending and match_count unchanged.
- Empty FIFO; DUT REG commit at pc=0x2010 while exp_valid=1 in the same cycle → code=7, exp_ready=0 next cycle, the push is not taken after FAIL.
- Fill 16 entries → exp_ready=0, pending=16. Matched commit plus push in the same cycle (no push when full, so pop-only) → pending=15, exp_ready=1. Then simultaneous push and pop → pending stays 15.
- Force a PC mismatch (exp pc=0x2020, DUT 0x2024, also inst differs) → code=1, not 2. Assert rst mid-FAIL → all outputs return to reset values asynchronously.
